run_merge16: RTL

- Merge stage for the sorting datapath: takes two already-sorted 8-element runs and emits one ascending 16-element sequence as a valid/ready stream.
- Sits downstream of the 8-element sorters. Two sorter result sets are presented in parallel on run_a/run_b with a start pulse.
- Ascending, stable merge: run_a wins ties. Together with the sorters this completes the run-sort-then-merge flow.

---
 rtl/run_merge16.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/run_merge16.sv
// run_merge16: merge stage for the sorting datapath.
// Captures two already-sorted 8-element runs on a start pulse and emits one
// ascending 16-element sequence over a valid/ready stream. The merge is
// stable: when keys are equal the element from run A is emitted first.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   begin a merge; only looked at in IDLE
//   run_a      in   N*W  sorted run A, element k at [k*W +: W], k=0 smallest
//   run_b      in   N*W  sorted run B, same packing
//   busy       out  high while merging (MERGE state)
//   out_valid  out  out_data holds a valid element
//   out_ready  in   downstream accepts the element
//   out_data   out  W    current merged element (0 when not valid)
//   out_last   out  high with the 16th element
//   done       out  one-cycle pulse after the final transfer
//
// Handshake: a transfer happens on a rising edge where out_valid && out_ready.
// While out_valid is high and out_ready is low, out_data/out_last stay
// stable and no pointer moves. out_valid never depends on out_ready.
//
// Debug visibility: state_q (FSM state), ia_q/ib_q (read pointers) and sel_a
// (1 = current element comes from run A) are plain named signals.
module run_merge16 #(
  parameter int W = 32,
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N*W-1:0] run_a,
  input  logic [N*W-1:0] run_b,
  output logic           busy,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic           out_last,
  output logic           done
);

  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MERGE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [3:0]   ia_q, ia_d;
  logic [3:0]   ib_q, ib_d;
  logic [W-1:0] a_q [N];
  logic [W-1:0] b_q [N];

  logic [W-1:0] a_head;
  logic [W-1:0] b_head;
  logic         sel_a;
  logic         last;
  logic         xfer;
  logic         capture;
  logic [4:0]   ptr_sum;

  // Pointers reach 8 once a run is exhausted; the low bits then wrap to 0,
  // but that head is never selected because sel_a checks the full pointer.
  assign a_head  = a_q[ia_q[IW-1:0]];
  assign b_head  = b_q[ib_q[IW-1:0]];
  assign ptr_sum = {1'b0, ia_q} + {1'b0, ib_q};
  assign last    = (ptr_sum == 5'd15);
  assign capture = (state_q == IDLE) && start;
  assign xfer    = (state_q == MERGE) && out_ready;

  // Source select: exhausted runs first, otherwise unsigned compare with
  // A winning ties (<=) to keep the merge stable.
  always_comb begin
    sel_a = 1'b0;
    if (ia_q == 4'd8) begin
      sel_a = 1'b0;
    end else if (ib_q == 4'd8) begin
      sel_a = 1'b1;
    end else begin
      sel_a = (a_head <= b_head);
    end
  end

  // Run storage has no reset: its contents only matter after a capture.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int k = 0; k < N; k++) begin
        a_q[k] <= run_a[k*W +: W];
        b_q[k] <= run_b[k*W +: W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ia_q    <= 4'd0;
      ib_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      ia_q    <= ia_d;
      ib_q    <= ib_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ia_d    = ia_q;
    ib_d    = ib_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          ia_d    = 4'd0;
          ib_d    = 4'd0;
          state_d = MERGE;
        end
      end
      MERGE: begin
        if (xfer) begin
          if (sel_a) begin
            ia_d = ia_q + 4'd1;
          end else begin
            ib_d = ib_q + 4'd1;
          end
          if (last) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode straight from registered state, so reset clears them
  // asynchronously and nothing reaches out_data from run_a/run_b.
  always_comb begin
    busy      = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    done      = 1'b0;
    case (state_q)
      MERGE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_last  = last;
        out_data  = sel_a ? a_head : b_head;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
